// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      TIMEOUT  = 2'd2
   } ctrl_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module load_use_detect #(
   parameter int AW = 5
) (
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic          id_uses_rt,
   input  logic          ex_mem_read,
   input  logic [AW-1:0] ex_rt,
   output logic          hazard
);
   import pipe_ctrl_pkg::*;

   // $zero never carries a real dependency
   assign hazard = ex_mem_read && (ex_rt != AW'(REG_ZERO)) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline buffer sequencing: load-use stall, branch flush, data-memory freeze with watchdog.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W   = pipe_ctrl_pkg::REG_ADDR_W,
   parameter int WAIT_TIMEOUT = 16,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  mem_access,
   input  logic                  dmem_ready,
   input  logic                  mem_branch_taken,
   input  logic                  err_clr,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  exmem_flush,
   output logic                  pipe_freeze,
   output logic                  mem_timeout,
   output logic [1:0]            ctrl_state,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      wait_cnt
);
   import pipe_ctrl_pkg::*;

   localparam int TW = $clog2(WAIT_TIMEOUT + 1);

   ctrl_state_t   state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic          lu_hazard, freeze;
   logic          stall_ev, flush_ev, wait_ev;

   load_use_detect #(.AW(REG_ADDR_W)) u_lud (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .hazard      (lu_hazard)
   );

   // TIMEOUT holds the pipe regardless of dmem_ready
   assign freeze   = (state == TIMEOUT) || (mem_access && !dmem_ready);
   assign wait_ev  = freeze;
   assign flush_ev = !freeze && mem_branch_taken;
   assign stall_ev = !freeze && !mem_branch_taken && lu_hazard;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_freeze = 1'b0;
      if (!reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (freeze) begin
         pipe_freeze = 1'b1;
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
      end else if (mem_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (lu_hazard) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer;
      case (state)
         RUN: if (freeze) begin
            state_nx = MEM_WAIT;
            timer_nx = TW'(1);
         end
         MEM_WAIT: if (!freeze) begin
            state_nx = RUN;
            timer_nx = '0;
         end else if (timer == TW'(WAIT_TIMEOUT - 1)) begin
            state_nx = TIMEOUT;
            timer_nx = '0;
         end else begin
            timer_nx = timer + TW'(1);
         end
         TIMEOUT: if (err_clr) state_nx = RUN;
         default: begin
            state_nx = RUN;
            timer_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= RUN;
         timer       <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         mem_timeout <= (state_nx == TIMEOUT);
      end
   end

   assign ctrl_state = state;

`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
         if (wait_ev  && wait_cnt  != '1) wait_cnt  <= wait_cnt + 1'b1;
      end
   end
`else
   logic unused_ev;
   assign unused_ev = stall_ev ^ flush_ev ^ wait_ev;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif
endmodule
